// File: rtl/car_game_pkg.sv
// Shared game encodings and screen geometry for the car lane game.
// Used by the control, drawing and obstacle blocks.
package car_game_pkg;

    typedef enum logic [1:0] {
        ST_TITLE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } game_state_t;

    localparam int SCREEN_W   = 320;
    localparam int LANE0_X    = 40;
    localparam int LANE_WIDTH = 40;
    localparam int NUM_LANES  = 3;

    function automatic logic [8:0] lane_x(
        input logic [1:0] idx,
        input int         x0,
        input int         pitch
    );
        return 9'(x0 + int'(idx) * pitch);
    endfunction

endpackage

// File: rtl/key_rise_detect.sv
// Press-event detector for one decoded key level.
// History resets high so a key held through reset stays silent.
module key_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b1;
        end else begin
            prev <= key;
        end
    end

    assign rise = key & ~prev;

endmodule

// File: rtl/car_lane_ctrl.sv
// Title/play/over state machine, lane index and car slide animation.
// Sits between the PS/2 key decoder and the VGA drawing stage.
module car_lane_ctrl #(
    parameter int NUM_LANES   = car_game_pkg::NUM_LANES,
    parameter int LANE0_X     = car_game_pkg::LANE0_X,
    parameter int LANE_WIDTH  = car_game_pkg::LANE_WIDTH,
    parameter int STEP_CYCLES = 250000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enter_en,
    input  logic       left_en,
    input  logic       right_en,
    input  logic       crash,
    output logic [1:0] game_state,
    output logic [1:0] lane,
    output logic [8:0] car_x,
    output logic       moving,
    output logic       game_start
);

    import car_game_pkg::*;

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [1:0]    CENTRE    = 2'(NUM_LANES / 2);
    localparam logic [1:0]    LAST_LANE = 2'(NUM_LANES - 1);

    game_state_t   state_q;
    logic [CW-1:0] step_cnt;

    logic enter_ev;
    logic left_ev;
    logic right_ev;

    logic [8:0] centre_x;
    logic [8:0] target_x;
    logic [8:0] next_x;
    logic       left_ok;
    logic       right_ok;
    logic       step_now;

    key_rise_detect u_enter (
        .clk   (CLOCK_50),
        .reset (reset),
        .key   (enter_en),
        .rise  (enter_ev)
    );

    key_rise_detect u_left (
        .clk   (CLOCK_50),
        .reset (reset),
        .key   (left_en),
        .rise  (left_ev)
    );

    key_rise_detect u_right (
        .clk   (CLOCK_50),
        .reset (reset),
        .key   (right_en),
        .rise  (right_ev)
    );

    assign centre_x = lane_x(CENTRE, LANE0_X, LANE_WIDTH);
    assign target_x = lane_x(lane, LANE0_X, LANE_WIDTH);
    assign next_x   = (car_x < target_x) ? car_x + 9'd1 : car_x - 9'd1;
    assign step_now = (step_cnt == CNT_LAST);

    // Simultaneous Left+Right cancel; no move starts mid-slide.
    assign left_ok  = left_ev & ~right_ev & ~moving & (lane != 2'd0);
    assign right_ok = right_ev & ~left_ev & ~moving & (lane != LAST_LANE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_TITLE;
            lane       <= CENTRE;
            car_x      <= centre_x;
            moving     <= 1'b0;
            game_start <= 1'b0;
            step_cnt   <= '0;
        end else begin
            game_start <= 1'b0;
            unique case (state_q)
                ST_TITLE: begin
                    lane     <= CENTRE;
                    car_x    <= centre_x;
                    moving   <= 1'b0;
                    step_cnt <= '0;
                    if (enter_ev) begin
                        state_q    <= ST_PLAY;
                        game_start <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (crash) begin
                        state_q <= ST_OVER;
                    end else if (left_ok) begin
                        lane   <= lane - 2'd1;
                        moving <= 1'b1;
                    end else if (right_ok) begin
                        lane   <= lane + 2'd1;
                        moving <= 1'b1;
                    end
                    // The slide keeps running on the crash edge itself.
                    if (moving) begin
                        if (step_now) begin
                            step_cnt <= '0;
                            car_x    <= next_x;
                            if (next_x == target_x) begin
                                moving <= 1'b0;
                            end
                        end else begin
                            step_cnt <= step_cnt + CW'(1);
                        end
                    end
                end
                ST_OVER: begin
                    if (enter_ev) begin
                        state_q  <= ST_TITLE;
                        lane     <= CENTRE;
                        car_x    <= centre_x;
                        moving   <= 1'b0;
                        step_cnt <= '0;
                    end
                end
                default: begin
                    state_q <= ST_TITLE;
                end
            endcase
        end
    end

    assign game_state = state_q;

endmodule

// File: doc/car_lane_ctrl.md
Name: car_lane_ctrl

Overview:
- Game-control stage directly downstream of the PS/2 key decoder.
- Consumes the decoder's Enter/Left/Right key-state levels and the collision flag from the track logic.
- Runs the title/play/game-over state machine and the player's lane index.
- Animates the car's horizontal pixel position between lanes at a fixed rate for the VGA drawing stage.

Parameters:
- NUM_LANES, 3, number of lanes (2..4).
- LANE0_X, 40, pixel x of lane 0 car origin.
- LANE_WIDTH, 40, pixel pitch between lanes; LANE0_X+(NUM_LANES-1)*LANE_WIDTH must be < 320.
- STEP_CYCLES, 250000, clock cycles per 1-pixel slide step (>=1).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enter_en  in  1  level, high while Enter is decoded as pressed.
- left_en  in  1  level, high while Left arrow is pressed.
- right_en  in  1  level, high while Right arrow is pressed.
- crash  in  1  level from track logic, car overlaps obstacle.
- game_state  out  2  0=TITLE, 1=PLAY, 2=OVER.
- lane  out  2  current target lane index, 0..NUM_LANES-1.
- car_x  out  9  current car pixel x.
- moving  out  1  high while car_x != lane target x.
- game_start  out  1  one-cycle pulse on TITLE->PLAY.

Behaviour:
- Reset (synchronous, dominates everything in the same edge):
  - game_state=TITLE, lane=NUM_LANES/2 (1 for default), car_x=LANE0_X+lane*LANE_WIDTH (80), moving=0, game_start=0, step counter=0.
  - Previous-value registers of the three key levels reset to 1, so a key held through reset produces no event until it is released and pressed again.
- Press event: a key input is 1 while its previous-value register is 0. The event acts on the same clock edge. A held level yields exactly one event.
- TITLE:
  - Enter event -> PLAY. game_start=1 for that one cycle.
  - lane and car_x reload to the centre lane values.
  - Left/Right events are ignored.
- PLAY:
  - crash=1 -> OVER next cycle. When crash coincides with a Left/Right event, crash wins and the move is dropped.
  - Left event with lane>0 and moving=0 -> lane-=1, moving=1.
  - Right event with lane<NUM_LANES-1 and moving=0 -> lane+=1, moving=1.
  - Left and Right events in the same cycle -> both ignored.
  - Events while moving=1, or at an edge lane, are ignored (no queuing).
  - Enter is ignored.
- Slide:
  - While moving=1 the step counter counts 0..STEP_CYCLES-1.
  - On terminal count, car_x steps 1 pixel toward LANE0_X+lane*LANE_WIDTH and the counter wraps to 0.
  - moving clears on the same edge car_x reaches the target.
  - A full lane change takes exactly LANE_WIDTH*STEP_CYCLES cycles from acceptance.
- OVER:
  - car_x, lane and the counter freeze; moving holds its value.
  - Enter event -> TITLE, which reloads lane/car_x to centre and sets moving=0.
- crash is ignored outside PLAY.
- Arithmetic is unsigned 9-bit. The target x is computed combinationally from lane and never wraps, guaranteed by the parameter constraint.

Decomposition:
- Shared package car_game_pkg:
  - game_state encodings TITLE/PLAY/OVER.
  - Screen constants: SCREEN_W=320, LANE0_X, LANE_WIDTH, NUM_LANES, so that the drawing and obstacle blocks share them.
- Sub-module key_rise_detect: one-bit previous-value register (reset to 1) plus event output. Instantiated three times.

Test Plan (STEP_CYCLES=4):
- Reset with enter_en held high, release, press again -> no transition while held; PLAY entered on second press, game_start high exactly 1 cycle, lane=1, car_x=80.
- In PLAY, pulse right_en -> lane=2 on the same edge, moving=1; car_x increments every 4 cycles, reaches 120 after 160 cycles, moving=0 on that edge.
- In PLAY at lane 0, press left_en -> no change; press right_en and hold for 500 cycles -> exactly one move (lane=1, car_x=80).
- During a slide, press left_en -> ignored; left_en and right_en rising together at rest -> lane unchanged.
- crash=1 in the same cycle as a right_en rise, mid-slide -> game_state=OVER next cycle, car_x frozen; Enter press -> TITLE, lane=1, car_x=80, moving=0.
- Assert reset mid-slide -> next edge TITLE, car_x=80, moving=0, counter=0.
